// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared definitions for the instruction-fetch block: FSM state
//           encoding, PC increment and default memory-timeout length.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_UPDATE = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam logic [15:0] PC_INC      = 16'd2;
  localparam int          TIMEOUT_DEF = 255;
  localparam int          TMR_W       = 8;   // wide enough for TIMEOUT up to 255

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_timer
// Purpose : Counts REQ-state cycles without a memory acknowledge and flags
//           the cycle on which the TIMEOUT-th such cycle occurs.
// Ports   : clk      - clock
//           rst_n    - asynchronous active-low reset
//           i_clear  - synchronous clear to zero
//           i_enable - count this cycle
//           o_tc     - terminal count: this enabled cycle is the TIMEOUT-th
// Revision: 1.0 - initial release
// ============================================================================
module fetch_timer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [TMR_W-1:0] c_LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  // Combinational so the FSM leaves REQ on exactly the TIMEOUT-th idle cycle.
  assign o_tc = i_enable && (r_count == c_LAST);

endmodule : fetch_timer
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch
// Purpose : Instruction-fetch FSM. Issues a memory read at the current PC,
//           loads the instruction register, pulses a PC write of PC+2, and
//           latches a sticky fault on misalignment or memory timeout.
// Ports   : CLK         - clock
//           reset       - asynchronous active-low reset
//           fetch_start - start a fetch at PCOut (honoured in IDLE only)
//           flush       - abandon an in-flight fetch
//           PCOut[15:0] - current program counter
//           mem_req     - memory read request (REQ state)
//           mem_addr    - memory byte address (0 outside REQ)
//           mem_rdata   - memory read data, valid with mem_ack
//           mem_ack     - single-cycle memory completion strobe
//           IR[15:0]    - instruction register
//           ir_valid    - one-cycle pulse on new IR
//           PCInA[15:0] - fetch address + 2
//           PCWrite     - one-cycle PC write enable
//           busy        - not IDLE
//           fault       - sticky error flag
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [15:0] PCOut,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] IR,
  output logic        ir_valid,
  output logic [15:0] PCInA,
  output logic        PCWrite,
  output logic        busy,
  output logic        fault
);

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_addr_q;
  logic        r_fault;

  logic w_start_ok;
  logic w_tmr_en;
  logic w_tmr_tc;

  assign w_start_ok = (r_state == ST_IDLE) && fetch_start && !PCOut[0];
  // Only REQ cycles that neither complete nor get flushed count toward timeout.
  assign w_tmr_en   = (r_state == ST_REQ) && !mem_ack && !flush;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (reset),
    .i_clear  (w_start_ok),
    .i_enable (w_tmr_en),
    .o_tc     (w_tmr_tc)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_ir     <= 16'h0000;
      r_addr_q <= 16'h0000;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fetch_start) begin
            if (PCOut[0]) begin
              r_state <= ST_ERR;
              r_fault <= 1'b1;
            end else begin
              r_addr_q <= PCOut;
              r_state  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // Flush wins over a same-cycle acknowledge: the data is discarded.
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_state <= ST_UPDATE;
          end else if (w_tmr_tc) begin
            r_state <= ST_ERR;
            r_fault <= 1'b1;
          end
        end
        ST_UPDATE: r_state <= ST_IDLE;
        ST_ERR:    r_fault <= 1'b1;   // held until reset
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from state so the async reset drops them immediately.
  assign mem_req  = (r_state == ST_REQ);
  assign mem_addr = (r_state == ST_REQ) ? r_addr_q : 16'h0000;
  assign PCWrite  = (r_state == ST_UPDATE);
  assign ir_valid = (r_state == ST_UPDATE);
  assign busy     = (r_state != ST_IDLE);
  assign PCInA    = r_addr_q + PC_INC;
  assign IR       = r_ir;
  assign fault    = r_fault;

endmodule : instr_fetch
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the number of REQ-state cycles without mem_ack before a fault is raised (range 1..255).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 fetch_start  input  1  SHALL be the control-unit request to fetch the instruction at PCOut.
REQ-005 flush  input  1  SHALL abandon any in-flight fetch.
REQ-006 PCOut  input  16  SHALL be the current program counter from the PC stage.
REQ-007 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-008 mem_addr  output  16  SHALL be the instruction-memory byte address.
REQ-009 mem_rdata  input  16  SHALL be the instruction-memory read data, valid when mem_ack=1.
REQ-010 mem_ack  input  1  SHALL be the single-cycle memory completion strobe.
REQ-011 IR  output  16  SHALL be the instruction register.
REQ-012 ir_valid  output  1  SHALL be a one-cycle pulse marking a new IR value.
REQ-013 PCInA  output  16  SHALL be the sequential next PC (fetch address + 2) driven to the PC stage.
REQ-014 PCWrite  output  1  SHALL be the one-cycle PC write-enable pulse to the PC stage.
REQ-015 busy  output  1  SHALL be 1 in every state except IDLE.
REQ-016 fault  output  1  SHALL be a sticky error flag (timeout or misalignment).

Function
REQ-017 FSM states SHALL be IDLE, REQ, UPDATE, ERR.
REQ-018 IDLE: on fetch_start=1 and PCOut[0]=0, the block SHALL capture addr_q<=PCOut, clear the timeout counter, and go to REQ.
REQ-019 IDLE: on fetch_start=1 and PCOut[0]=1, the block SHALL go to ERR without asserting mem_req.
REQ-020 REQ: mem_req SHALL be 1 and mem_addr SHALL equal addr_q for every cycle in REQ; mem_addr SHALL be 0x0000 outside REQ.
REQ-021 REQ: on mem_ack=1 and flush=0, the block SHALL load IR<=mem_rdata and go to UPDATE.
REQ-022 REQ: the counter SHALL increment on each cycle without mem_ack; on reaching TIMEOUT the block SHALL go to ERR.
REQ-023 UPDATE: PCWrite and ir_valid SHALL both be 1 for exactly that one cycle, and the next state SHALL be IDLE.
REQ-024 PCInA SHALL be addr_q+2, modulo 2^16, at all times (0xFFFE wraps to 0x0000).
REQ-025 flush=1 in REQ SHALL return the block to IDLE with IR unchanged and no PCWrite/ir_valid, even if mem_ack=1 in the same cycle.
REQ-026 flush in IDLE, UPDATE, or ERR SHALL have no effect.
REQ-027 fetch_start SHALL be ignored in every state except IDLE.
REQ-028 ERR: fault SHALL be 1, mem_req SHALL be 0, and the block SHALL remain in ERR until reset.
REQ-029 IR SHALL change only on the transition from REQ to UPDATE.
REQ-030 Fetch latency SHALL be 1 (REQ entry) + N memory cycles + 1 (UPDATE); the minimum, with mem_ack in the first REQ cycle, SHALL be 3 cycles from fetch_start to the PCWrite cycle.

Reset
REQ-031 reset=0 SHALL force state=IDLE, IR=0x0000, addr_q=0x0000, counter=0, and fault=0.
REQ-032 Under reset, mem_req, PCWrite, ir_valid, and busy SHALL be 0, and PCInA SHALL be 0x0002.
REQ-033 reset asserted during REQ SHALL drop mem_req immediately (asynchronously); a mem_ack arriving after reset release SHALL be ignored in IDLE.

Structure
REQ-034 A shared package fetch_pkg SHALL hold the state enumeration, PC_INC=2, and the TIMEOUT default.
REQ-035 The timeout counter SHALL be a sub-module named fetch_timer (clear, enable, terminal-count output).
REQ-036 IR, addr_q, and fault SHALL be registers; all outputs other than IR and fault SHALL be decoded from state and addr_q.

Verification
REQ-037 Basic fetch: PCOut=0x0010, fetch_start pulse, mem_ack with rdata=0xA5C3 in the 2nd REQ cycle -> IR=0xA5C3, PCInA=0x0012, one PCWrite pulse, busy falls.
REQ-038 Wrap: PCOut=0xFFFE fetch, immediate ack -> PCInA=0x0000, PCWrite=1 for one cycle only.
REQ-039 Flush race: in REQ, assert flush and mem_ack (rdata=0x1234) in the same cycle -> IR unchanged, no PCWrite, state IDLE next cycle.
REQ-040 Timeout: TIMEOUT=4, no ack -> fault=1 after 4 REQ cycles, mem_req=0, further fetch_start ignored until reset.
REQ-041 Misalign: PCOut=0x0011 fetch -> mem_req never asserted, fault=1 next cycle.
REQ-042 Reset mid-fetch: reset low during REQ -> mem_req=0 immediately, IR=0x0000, and a later stray mem_ack causes no ir_valid.
